w_bus_word_receiver: RTL and testbench
======================================

# w_bus_word_receiver

Sink-side counterpart of the program counter's W-bus drivers. Samples the 16-bit W bus and assembles a 16-bit word either in one transfer or from 8-bit transfers on bus lanes [7:0] (low/high byte halves, matching the PC's eLow/eHigh lane usage). A two-byte sequencer is included. The block feeds the memory address register and jump/call target paths in the SAP-2 datapath.

## Interface
- pWidth, 16, word width; must be even; byte width is pWidth/2
- iClk  input  1  clock; all state updates on rising edge
- iReset  input  1  synchronous, active-high reset
- tWbus  input  16  W bus, sampled only; never driven by this block
- iLoadFull  input  1  capture tWbus[15:0] into the word
- iLoadLow  input  1  capture tWbus[7:0] into word[7:0]
- iLoadHigh  input  1  capture tWbus[7:0] into word[15:8]
- iByteStrobe  input  1  sequenced byte on tWbus[7:0]; first strobe is the low byte, second is the high byte
- iAbort  input  1  discard a partially received sequence
- oWord  output  16  assembled word
- oWordValid  output  1  one-cycle pulse; oWord was updated at the last edge
- oPending  output  1  low byte staged, high byte awaited
- oDropped  output  1  sticky; a pending sequence was discarded by a direct load or an abort

## Operation
- States: IDLE, GOT_LOW.
- Priority per edge: iReset > iAbort > direct loads (iLoadFull > iLoadLow/iLoadHigh) > iByteStrobe. Only the highest-priority active request acts. Lower requests in the same cycle are ignored, with no side effects.
- iLoadFull: oWord <= tWbus; oWordValid pulses.
- iLoadLow only: oWord[7:0] <= tWbus[7:0]; upper byte held; pulse.
- iLoadHigh only: oWord[15:8] <= tWbus[7:0]; lower byte held; pulse.
- iLoadLow and iLoadHigh together: oWord <= {tWbus[7:0], tWbus[7:0]}; pulse.
- iByteStrobe in IDLE: stage <= tWbus[7:0]; go to GOT_LOW; oWord unchanged; no pulse.
- iByteStrobe in GOT_LOW: oWord <= {tWbus[7:0], stage}; go to IDLE; pulse.
- A direct load in GOT_LOW: the load applies, the state goes to IDLE, the stage is discarded, and oDropped is set.
- iAbort in GOT_LOW: go to IDLE and set oDropped. iAbort in IDLE has no effect.
- The stage register is not cleared on abort or drop. Its content is don't-care outside GOT_LOW.
- oDropped clears only on reset.
- Bus values containing z/x are captured as-is. Bus arbitration is the controller's responsibility.

## Timing
- Reset values: oWord = 0x0000, oWordValid = 0, oPending = 0, oDropped = 0, state = IDLE, stage = 0x00.
- All outputs are registered.
- A load sampled at edge N is visible on oWord after edge N. oWordValid is high exactly for the cycle between edges N and N+1.
- oPending = (state == GOT_LOW). It rises after the first strobe edge and falls after the completing, aborting or dropping edge.
- Back-to-back strobes on consecutive cycles complete a word every second cycle with no bubble. Continuous strobing yields one pulse per two strobes.
- Reset asserted mid-sequence returns all outputs to reset values at the next edge, oDropped included. No pulse occurs.
- There is no timeout. GOT_LOW is held indefinitely until the next strobe, a direct load, an abort or a reset.

## Structure
- The shared package holds:
  - the state enum (IDLE, GOT_LOW);
  - the byte-width constant, derived as pWidth/2;
  - the reset-value constants.
- One sub-module, w_bus_byte_reg: a byte register with synchronous reset and load enable. Instantiate it for oWord low, oWord high and the stage register.
- The FSM, priority decode and oWordValid/oDropped flops stay in the top module.

## Test plan
- Reset: drive iReset for 2 cycles with the bus at 0xFFFF -> oWord = 0x0000, oWordValid = 0, oPending = 0, oDropped = 0.
- Full load: bus = 0xBEEF, iLoadFull for 1 cycle -> oWord = 0xBEEF next cycle; oWordValid is a single 1-cycle pulse.
- Byte halves:
  - oWord = 0xBEEF; iLoadLow with bus[7:0] = 0x12 -> oWord = 0xBE12.
  - Then iLoadHigh with bus[7:0] = 0x34 -> oWord = 0x3412.
  - Then iLoadLow and iLoadHigh together with bus[7:0] = 0x5A -> oWord = 0x5A5A.
- Sequence:
  - iByteStrobe with bus[7:0] = 0x34 -> oPending = 1, oWord unchanged, no pulse.
  - Two idle cycles, then iByteStrobe with bus[7:0] = 0x12 -> oWord = 0x1234, one pulse, oPending = 0.
  - Four consecutive strobes (0x01, 0x02, 0x03, 0x04) -> oWord = 0x0201, then 0x0403, with exactly 2 pulses.
- Drop/abort:
  - Strobe 0x34, then iLoadFull with bus = 0xCAFE -> oWord = 0xCAFE, oPending = 0, oDropped = 1.
  - Then strobe 0x77 and strobe 0x66 -> oWord = 0x6677 (the stale stage byte is not used).
  - Separately, strobe then iAbort -> oDropped = 1, no pulse.
- Priority/reset mid-op:
  - iAbort, iLoadFull and iByteStrobe in the same cycle while in GOT_LOW -> only the abort acts; oWord unchanged.
  - Strobe 0x34, then iReset together with iByteStrobe -> all reset values, no pulse.

Source files
------------

// File: rtl/w_bus_word_receiver_pkg.sv
// Shared types and constants for the W-bus word receiver: state encoding,
// byte-lane width and the values every register returns to on reset.
package w_bus_word_receiver_pkg;

    localparam int P_WIDTH = 16;
    localparam int BYTE_W  = P_WIDTH / 2;

    typedef enum logic {
        IDLE    = 1'b0,
        GOT_LOW = 1'b1
    } state_e;

    localparam logic [P_WIDTH-1:0] WORD_RESET  = '0;
    localparam logic [BYTE_W-1:0]  STAGE_RESET = '0;

endpackage

// File: rtl/w_bus_byte_reg.sv
// One byte of storage with synchronous reset and a load enable; used for both
// halves of the output word and for the staged low byte.
module w_bus_byte_reg
    import w_bus_word_receiver_pkg::*;
#(
    parameter int                pWidth      = BYTE_W,
    parameter logic [pWidth-1:0] pResetValue = '0
) (
    input  logic              iClk,
    input  logic              iReset,
    input  logic              iLoad,
    input  logic [pWidth-1:0] iData,
    output logic [pWidth-1:0] oData
);

    logic [pWidth-1:0] data_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge iClk) begin
        if (iReset) begin
            data_q <= pResetValue;
        end else if (iLoad) begin
            data_q <= iData;
        end
    end

    assign oData = data_q;

endmodule

// File: rtl/w_bus_word_receiver.sv
// Samples the W bus and assembles a word from a full transfer, from direct
// byte-half loads, or from a low-then-high two-strobe byte sequence.
module w_bus_word_receiver
    import w_bus_word_receiver_pkg::*;
#(
    parameter int pWidth = P_WIDTH
) (
    input  logic              iClk,
    input  logic              iReset,
    input  logic [pWidth-1:0] tWbus,
    input  logic              iLoadFull,
    input  logic              iLoadLow,
    input  logic              iLoadHigh,
    input  logic              iByteStrobe,
    input  logic              iAbort,
    output logic [pWidth-1:0] oWord,
    output logic              oWordValid,
    output logic              oPending,
    output logic              oDropped
);

    localparam int lByteW = pWidth / 2;

    state_e            state_q, state_d;
    logic              valid_q, valid_d;
    logic              pending_q;
    logic              dropped_q, dropped_d;

    logic              load_lo, load_hi, load_stage;
    logic [lByteW-1:0] lo_d, hi_d;
    logic [lByteW-1:0] word_lo, word_hi, stage;
    logic [lByteW-1:0] bus_lo, bus_hi;

    assign bus_lo = tWbus[lByteW-1:0];
    assign bus_hi = tWbus[pWidth-1:lByteW];

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        dropped_d  = dropped_q;
        valid_d    = 1'b0;
        load_lo    = 1'b0;
        load_hi    = 1'b0;
        load_stage = 1'b0;
        lo_d       = bus_lo;
        hi_d       = bus_lo;

        if (iAbort) begin
            if (state_q == GOT_LOW) begin
                state_d   = IDLE;
                dropped_d = 1'b1;
            end
        end else if (iLoadFull || iLoadLow || iLoadHigh) begin
            load_lo = iLoadFull || iLoadLow;
            load_hi = iLoadFull || iLoadHigh;
            if (iLoadFull) begin
                hi_d = bus_hi;
            end
            valid_d = 1'b1;
            // A direct load always wins over a half-received sequence.
            if (state_q == GOT_LOW) begin
                state_d   = IDLE;
                dropped_d = 1'b1;
            end
        end else if (iByteStrobe) begin
            if (state_q == IDLE) begin
                load_stage = 1'b1;
                state_d    = GOT_LOW;
            end else begin
                load_lo = 1'b1;
                load_hi = 1'b1;
                lo_d    = stage;
                valid_d = 1'b1;
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge iClk) begin
        if (iReset) begin
            state_q   <= IDLE;
            valid_q   <= 1'b0;
            pending_q <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            pending_q <= (state_d == GOT_LOW);
            dropped_q <= dropped_d;
        end
    end

    w_bus_byte_reg #(
        .pWidth      (lByteW),
        .pResetValue (WORD_RESET[lByteW-1:0])
    ) u_word_lo (
        .iClk   (iClk),
        .iReset (iReset),
        .iLoad  (load_lo),
        .iData  (lo_d),
        .oData  (word_lo)
    );

    w_bus_byte_reg #(
        .pWidth      (lByteW),
        .pResetValue (WORD_RESET[pWidth-1:lByteW])
    ) u_word_hi (
        .iClk   (iClk),
        .iReset (iReset),
        .iLoad  (load_hi),
        .iData  (hi_d),
        .oData  (word_hi)
    );

    // Stage is reset for determinism but otherwise never cleared; its value
    // only matters while in GOT_LOW.
    w_bus_byte_reg #(
        .pWidth      (lByteW),
        .pResetValue (STAGE_RESET[lByteW-1:0])
    ) u_stage (
        .iClk   (iClk),
        .iReset (iReset),
        .iLoad  (load_stage),
        .iData  (bus_lo),
        .oData  (stage)
    );

    assign oWord      = {word_hi, word_lo};
    assign oWordValid = valid_q;
    assign oPending   = pending_q;
    assign oDropped   = dropped_q;

endmodule

// File: tb/tb_w_bus_word_receiver.sv
// Bench for w_bus_word_receiver: directed vector table, a long-hold sequence,
// and randomized traffic compared against a behavioural model.
module tb_w_bus_word_receiver;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] bus;
    logic        full, low, high, strobe, abort;
    logic [15:0] word;
    logic        valid, pending, dropped;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    w_bus_word_receiver dut (
        .iClk        (clk),
        .iReset      (rst),
        .tWbus       (bus),
        .iLoadFull   (full),
        .iLoadLow    (low),
        .iLoadHigh   (high),
        .iByteStrobe (strobe),
        .iAbort      (abort),
        .oWord       (word),
        .oWordValid  (valid),
        .oPending    (pending),
        .oDropped    (dropped)
    );

    typedef struct {
        logic        rst, abort, full, low, high, strobe;
        logic [15:0] bus;
        logic [15:0] e_word;
        logic        e_valid, e_pend, e_drop;
    } vec_t;

    vec_t vecs[$];

    // Behavioural reference model state.
    int unsigned m_word, m_stage;
    bit          m_pend, m_drop, m_valid;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic a, input logic f, input logic l,
                         input logic h, input logic s, input logic [15:0] b);
        rst = r; abort = a; full = f; low = l; high = h; strobe = s; bus = b;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic [15:0] w, input logic v,
                              input logic p, input logic d);
        check({tag, " word"},    32'(word),    32'(w));
        check({tag, " valid"},   32'(valid),   32'(v));
        check({tag, " pending"}, 32'(pending), 32'(p));
        check({tag, " dropped"}, 32'(dropped), 32'(d));
    endtask

    function automatic vec_t mk(input logic r, input logic a, input logic f, input logic l,
                                input logic h, input logic s, input logic [15:0] b,
                                input logic [15:0] w, input logic v, input logic p,
                                input logic d);
        vec_t t;
        t.rst = r; t.abort = a; t.full = f; t.low = l; t.high = h; t.strobe = s;
        t.bus = b; t.e_word = w; t.e_valid = v; t.e_pend = p; t.e_drop = d;
        return t;
    endfunction

    // One clock of the receiver's behaviour, from its stated rules.
    task automatic model_step(input bit r, input bit a, input bit f, input bit l,
                              input bit h, input bit s, input int unsigned b);
        int unsigned lo_byte = b % 256;
        if (r) begin
            m_word = 0; m_stage = 0; m_pend = 0; m_drop = 0; m_valid = 0;
            return;
        end
        m_valid = 0;
        if (a) begin
            if (m_pend) m_drop = 1;
            m_pend = 0;
        end else if (f || l || h) begin
            if (f) begin
                m_word = b;
            end else begin
                if (l) m_word = (m_word / 256) * 256 + lo_byte;
                if (h) m_word = lo_byte * 256 + (m_word % 256);
            end
            m_valid = 1;
            if (m_pend) m_drop = 1;
            m_pend = 0;
        end else if (s) begin
            if (!m_pend) begin
                m_stage = lo_byte;
                m_pend  = 1;
            end else begin
                m_word  = lo_byte * 256 + m_stage;
                m_valid = 1;
                m_pend  = 0;
            end
        end
    endtask

    initial begin
        //           rst a f l h s  bus        word      v p d
        vecs.push_back(mk(1,0,0,0,0,0, 16'hFFFF, 16'h0000, 0,0,0));
        vecs.push_back(mk(1,0,0,0,0,0, 16'hFFFF, 16'h0000, 0,0,0));
        vecs.push_back(mk(0,0,1,0,0,0, 16'hBEEF, 16'hBEEF, 1,0,0));
        vecs.push_back(mk(0,0,0,0,0,0, 16'h0000, 16'hBEEF, 0,0,0));
        vecs.push_back(mk(0,0,0,1,0,0, 16'hAB12, 16'hBE12, 1,0,0));
        vecs.push_back(mk(0,0,0,0,1,0, 16'hCD34, 16'h3412, 1,0,0));
        vecs.push_back(mk(0,0,0,1,1,0, 16'h775A, 16'h5A5A, 1,0,0));
        vecs.push_back(mk(0,0,0,0,0,1, 16'hF034, 16'h5A5A, 0,1,0));
        vecs.push_back(mk(0,0,0,0,0,0, 16'h0000, 16'h5A5A, 0,1,0));
        vecs.push_back(mk(0,0,0,0,0,0, 16'h0000, 16'h5A5A, 0,1,0));
        vecs.push_back(mk(0,0,0,0,0,1, 16'hE012, 16'h1234, 1,0,0));
        vecs.push_back(mk(0,0,0,0,0,1, 16'h0001, 16'h1234, 0,1,0));
        vecs.push_back(mk(0,0,0,0,0,1, 16'h0002, 16'h0201, 1,0,0));
        vecs.push_back(mk(0,0,0,0,0,1, 16'h0003, 16'h0201, 0,1,0));
        vecs.push_back(mk(0,0,0,0,0,1, 16'h0004, 16'h0403, 1,0,0));
        vecs.push_back(mk(0,0,0,0,0,1, 16'h0034, 16'h0403, 0,1,0));
        vecs.push_back(mk(0,0,1,0,0,0, 16'hCAFE, 16'hCAFE, 1,0,1));
        vecs.push_back(mk(0,0,0,0,0,1, 16'h0077, 16'hCAFE, 0,1,1));
        vecs.push_back(mk(0,0,0,0,0,1, 16'h0066, 16'h6677, 1,0,1));
        vecs.push_back(mk(0,0,0,0,0,1, 16'h0011, 16'h6677, 0,1,1));
        vecs.push_back(mk(0,1,0,0,0,0, 16'h0000, 16'h6677, 0,0,1));
        vecs.push_back(mk(0,0,0,0,0,1, 16'h0022, 16'h6677, 0,1,1));
        vecs.push_back(mk(0,1,1,0,0,1, 16'h9999, 16'h6677, 0,0,1));
        vecs.push_back(mk(0,1,0,0,0,0, 16'h0000, 16'h6677, 0,0,1));
        vecs.push_back(mk(0,0,0,0,0,1, 16'h0034, 16'h6677, 0,1,1));
        vecs.push_back(mk(1,0,0,0,0,1, 16'h0012, 16'h0000, 0,0,0));
        vecs.push_back(mk(0,0,0,0,0,1, 16'h00AB, 16'h0000, 0,1,0));
        vecs.push_back(mk(0,1,0,0,0,0, 16'h0000, 16'h0000, 0,0,1));
        vecs.push_back(mk(1,0,0,0,0,0, 16'h0000, 16'h0000, 0,0,0));
        vecs.push_back(mk(0,0,0,0,0,1, 16'h0055, 16'h0000, 0,1,0));
        vecs.push_back(mk(0,0,0,0,1,0, 16'h11EE, 16'hEE00, 1,0,1));

        drive(1, 0, 0, 0, 0, 0, 16'hFFFF);
        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].abort, vecs[i].full, vecs[i].low,
                  vecs[i].high, vecs[i].strobe, vecs[i].bus);
            tick();
            check_outs($sformatf("vec%0d", i), vecs[i].e_word, vecs[i].e_valid,
                       vecs[i].e_pend, vecs[i].e_drop);
        end

        // GOT_LOW has no timeout: hold it for a long idle stretch.
        drive(1, 0, 0, 0, 0, 0, 16'h0000);
        tick();
        drive(0, 0, 0, 0, 0, 1, 16'h00C3);
        tick();
        drive(0, 0, 0, 0, 0, 0, 16'hFFFF);
        for (int i = 0; i < 30; i++) begin
            tick();
            if (pending !== 1'b1 || valid !== 1'b0) begin
                check($sformatf("hold%0d pending", i), 32'(pending), 32'd1);
                check($sformatf("hold%0d valid", i), 32'(valid), 32'd0);
            end
        end
        check("hold end pending", 32'(pending), 32'd1);
        drive(0, 0, 0, 0, 0, 1, 16'h003C);
        tick();
        check_outs("hold done", 16'h3CC3, 1'b1, 1'b0, 1'b0);

        // Randomized traffic against the behavioural model.
        drive(1, 0, 0, 0, 0, 0, 16'h0000);
        model_step(1, 0, 0, 0, 0, 0, 0);
        tick();
        for (int i = 0; i < 400; i++) begin
            bit r, a, f, l, h, s;
            int unsigned b;
            r = ($urandom_range(39) == 0);
            a = ($urandom_range(9) == 0);
            f = ($urandom_range(9) == 0);
            l = ($urandom_range(7) == 0);
            h = ($urandom_range(7) == 0);
            s = ($urandom_range(1) == 0);
            b = $urandom_range(16'hFFFF);
            drive(r, a, f, l, h, s, 16'(b));
            model_step(r, a, f, l, h, s, b);
            tick();
            check_outs($sformatf("rnd%0d", i), 16'(m_word), m_valid, m_pend, m_drop);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
